// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg : shared types and constants for the register-file write arbiter
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rf_arb_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_REQ0 = 2'b01;
  localparam logic [1:0] GRANT_REQ1 = 2'b10;

endpackage

`default_nettype wire

// File: rtl/rf_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_wr_arbiter_if : requester handshakes, clear control and write port bundle
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rf_wr_arbiter_if;
  import rf_arb_pkg::*;

  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [REG_AW-1:0] req0_wR_i;
  logic [DATA_W-1:0] req0_wD_i;
  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [REG_AW-1:0] req1_wR_i;
  logic [DATA_W-1:0] req1_wD_i;
  logic              clr_start_i;
  logic              clr_busy_o;
  logic [REG_AW-1:0] wR_o;
  logic [DATA_W-1:0] wD_o;
  logic              WE_o;
  logic [1:0]        grant_o;

  modport slave (
    input  req0_valid_i, req0_wR_i, req0_wD_i,
    input  req1_valid_i, req1_wR_i, req1_wD_i,
    input  clr_start_i,
    output req0_ready_o, req1_ready_o, clr_busy_o,
    output wR_o, wD_o, WE_o, grant_o
  );

  modport master (
    output req0_valid_i, req0_wR_i, req0_wD_i,
    output req1_valid_i, req1_wR_i, req1_wD_i,
    output clr_start_i,
    input  req0_ready_o, req1_ready_o, clr_busy_o,
    input  wR_o, wD_o, WE_o, grant_o
  );

endinterface

`default_nettype wire

// File: rtl/rf_clr_seq.sv
// ---------------------------------------------------------------------------
// rf_clr_seq : clear-sweep FSM, issues one index per CLEAR cycle up to 31
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rf_clr_seq
  import rf_arb_pkg::*;
#(
  parameter int unsigned CLR_START = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic [REG_AW-1:0] idx_o
);

  localparam logic [REG_AW-1:0] START_IDX = REG_AW'(CLR_START);
  localparam logic [REG_AW-1:0] LAST_IDX  = REG_AW'(NUM_REGS - 1);

  clr_state_e        state_q;
  logic [REG_AW-1:0] idx_q;
  logic              busy_q;

  // start_i is only looked at in IDLE, so a pulse mid-sweep cannot restart it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= START_IDX;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (idx_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            idx_q   <= START_IDX;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          idx_q   <= START_IDX;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign idx_o  = idx_q;

endmodule

`default_nettype wire

// File: rtl/rf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wr_arbiter : two-requester register-file write arbiter with clear sweep
//                 RF_ARB_RR_EN defined -> round-robin, else req0 fixed priority
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rf_wr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned CLR_START = 1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  rf_wr_arbiter_if.slave bus
);

  logic              sweep_busy;
  logic [REG_AW-1:0] sweep_idx;
  logic              arb_en;
  logic              gnt0;
  logic              gnt1;

  logic              we_d,    we_q;
  logic [REG_AW-1:0] wr_d,    wr_q;
  logic [DATA_W-1:0] wd_d,    wd_q;
  logic [1:0]        grant_d, grant_q;

  rf_clr_seq #(
    .CLR_START (CLR_START)
  ) u_clr_seq (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (bus.clr_start_i),
    .busy_o  (sweep_busy),
    .idx_o   (sweep_idx)
  );

  // A clear request in the same cycle beats both requesters.
  assign arb_en = !reset_i && !sweep_busy && !bus.clr_start_i;

`ifdef RF_ARB_RR_EN
  logic prefer1_q;

  assign gnt1 = arb_en && bus.req1_valid_i && (!bus.req0_valid_i || prefer1_q);
  assign gnt0 = arb_en && bus.req0_valid_i && !gnt1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prefer1_q <= 1'b0;
    end else if (gnt0) begin
      prefer1_q <= 1'b1;
    end else if (gnt1) begin
      prefer1_q <= 1'b0;
    end
  end
`else
  assign gnt0 = arb_en && bus.req0_valid_i;
  assign gnt1 = arb_en && bus.req1_valid_i && !bus.req0_valid_i;
`endif

  assign bus.req0_ready_o = gnt0;
  assign bus.req1_ready_o = gnt1;

  // Accepted writes to r0 are swallowed: the write port keeps its last address/data.
  always_comb begin
    we_d    = 1'b0;
    wr_d    = wr_q;
    wd_d    = wd_q;
    grant_d = GRANT_NONE;
    if (sweep_busy) begin
      we_d = 1'b1;
      wr_d = sweep_idx;
      wd_d = '0;
    end else if (gnt0 && (bus.req0_wR_i != '0)) begin
      we_d    = 1'b1;
      wr_d    = bus.req0_wR_i;
      wd_d    = bus.req0_wD_i;
      grant_d = GRANT_REQ0;
    end else if (gnt1 && (bus.req1_wR_i != '0)) begin
      we_d    = 1'b1;
      wr_d    = bus.req1_wR_i;
      wd_d    = bus.req1_wD_i;
      grant_d = GRANT_REQ1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      we_q    <= 1'b0;
      wr_q    <= '0;
      wd_q    <= '0;
      grant_q <= GRANT_NONE;
    end else begin
      we_q    <= we_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
      grant_q <= grant_d;
    end
  end

  assign bus.WE_o       = we_q;
  assign bus.wR_o       = wr_q;
  assign bus.wD_o       = wd_q;
  assign bus.grant_o    = grant_q;
  assign bus.clr_busy_o = sweep_busy;

endmodule

`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wr_arbiter : directed + random bench against a queue-based model
//                    honours RF_ARB_RR_EN the same way as the design
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rf_wr_arbiter;
  import rf_arb_pkg::*;

  localparam int unsigned CLR_START = 1;
`ifdef RF_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_wr_arbiter_if bus();

  rf_wr_arbiter #(
    .CLR_START (CLR_START)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  // Reference model: pending sweep writes are simply a queue of indices.
  int          sweep_q[$];
  bit          prefer1;
  logic        exp_we;
  logic [4:0]  exp_wr;
  logic [31:0] exp_wd;
  logic [1:0]  exp_grant;
  logic        exp_busy;
  bit          acc0, acc1;

  int          n_pass = 0;
  int          n_chk  = 0;

  logic        s_rdy0, s_we;
  logic [4:0]  s_wr;
  logic [31:0] s_wd;
  logic [1:0]  s_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    int w;
    w    = -1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (reset) begin
      sweep_q.delete();
      prefer1   = 1'b0;
      exp_we    = 1'b0;
      exp_wr    = '0;
      exp_wd    = '0;
      exp_grant = 2'b00;
      exp_busy  = 1'b0;
    end else if (sweep_q.size() > 0) begin
      exp_we    = 1'b1;
      exp_wr    = 5'(sweep_q.pop_front());
      exp_wd    = '0;
      exp_grant = 2'b00;
      exp_busy  = (sweep_q.size() > 0);
    end else if (bus.clr_start_i) begin
      for (int i = CLR_START; i < NUM_REGS; i++) sweep_q.push_back(i);
      exp_we    = 1'b0;
      exp_grant = 2'b00;
      exp_busy  = 1'b1;
    end else begin
      if (bus.req0_valid_i && bus.req1_valid_i) w = (RR && prefer1) ? 1 : 0;
      else if (bus.req0_valid_i) w = 0;
      else if (bus.req1_valid_i) w = 1;
      exp_we    = 1'b0;
      exp_grant = 2'b00;
      exp_busy  = 1'b0;
      if (w == 0) begin
        acc0    = 1'b1;
        prefer1 = 1'b1;
        if (bus.req0_wR_i != 0) begin
          exp_we = 1'b1; exp_wr = bus.req0_wR_i; exp_wd = bus.req0_wD_i; exp_grant = 2'b01;
        end
      end else if (w == 1) begin
        acc1    = 1'b1;
        prefer1 = 1'b0;
        if (bus.req1_wR_i != 0) begin
          exp_we = 1'b1; exp_wr = bus.req1_wR_i; exp_wd = bus.req1_wD_i; exp_grant = 2'b10;
        end
      end
    end
  endtask

  // One clock: inputs already driven after the falling edge.
  task automatic cycle();
    #1;
    model_step();
    s_rdy0 = bus.req0_ready_o;
    check("req0_ready", bus.req0_ready_o, acc0);
    check("req1_ready", bus.req1_ready_o, acc1);
    @(posedge clk);
    #1;
    s_we = bus.WE_o; s_wr = bus.wR_o; s_wd = bus.wD_o; s_grant = bus.grant_o;
    check("WE_o", bus.WE_o, exp_we);
    check("wR_o", bus.wR_o, exp_wr);
    check("wD_o", bus.wD_o, exp_wd);
    check("grant_o", bus.grant_o, exp_grant);
    check("clr_busy_o", bus.clr_busy_o, exp_busy);
    @(negedge clk);
  endtask

  task automatic set_req(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    bus.req0_valid_i = v0; bus.req0_wR_i = r0; bus.req0_wD_i = d0;
    bus.req1_valid_i = v1; bus.req1_wR_i = r1; bus.req1_wD_i = d1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] gpat;
    int         zeros, sweeps;
    bit         done, pend0, pend1;

    reset = 1'b1;
    bus.clr_start_i = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    cycle();
    set_req(1, 5'd4, 32'h1, 1, 5'd6, 32'h2);
    cycle();

    // Single req0 write
    reset = 1'b0;
    set_req(1, 5'd5, 32'h12345678, 0, 0, 0);
    cycle();
    check("single_req0_ready", s_rdy0, 1'b1);
    set_req(0, 5'd5, 32'h12345678, 0, 0, 0);
    cycle();

    // Write to r0 is accepted but produces no write
    set_req(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    cycle();
    check("r0_no_we", s_we, 1'b0);
    set_req(0, 0, 0, 0, 0, 0);
    cycle();

    // Contention for four cycles
    set_req(1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
    gpat = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      gpat = {gpat[5:0], s_grant};
    end
    check("contention_grants", gpat, RR ? 8'b01100110 : 8'b01010101);
    set_req(0, 0, 0, 0, 0, 0);
    cycle();

    // Clear sweep with req0 waiting, plus an ignored restart pulse mid-sweep
    set_req(1, 5'd9, 32'hAA, 0, 0, 0);
    bus.clr_start_i = 1'b1;
    zeros = 0; sweeps = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      bus.clr_start_i = (i == 5);
      if (s_rdy0) done = 1'b1;
      else zeros++;
      if (s_we && s_grant == 2'b00 && s_wd == 0) sweeps++;
    end
    bus.clr_start_i = 1'b0;
    check("sweep_stall_cycles", zeros, 32);
    check("sweep_write_count", sweeps, 31);
    set_req(0, 0, 0, 0, 0, 0);
    cycle();

    // Reset in the middle of a sweep, then restart from CLR_START
    bus.clr_start_i = 1'b1;
    cycle();
    bus.clr_start_i = 1'b0;
    for (int i = 0; i < 9; i++) cycle();
    reset = 1'b1;
    cycle();
    check("abort_we", s_we, 1'b0);
    reset = 1'b0;
    bus.clr_start_i = 1'b1;
    cycle();
    bus.clr_start_i = 1'b0;
    cycle();
    check("restart_first_idx", s_wr, 5'(CLR_START));
    for (int i = 0; i < 32; i++) cycle();

    // Random traffic; requesters hold their request until accepted
    pend0 = 1'b0; pend1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0) begin
        bus.req0_valid_i = $urandom_range(0, 1) == 1;
        bus.req0_wR_i    = 5'($urandom_range(0, 31));
        bus.req0_wD_i    = $urandom;
      end
      if (!pend1) begin
        bus.req1_valid_i = $urandom_range(0, 1) == 1;
        bus.req1_wR_i    = 5'($urandom_range(0, 31));
        bus.req1_wD_i    = $urandom;
      end
      bus.clr_start_i = $urandom_range(0, 39) == 0;
      reset           = $urandom_range(0, 99) == 0;
      cycle();
      pend0 = bus.req0_valid_i && !acc0;
      pend1 = bus.req1_valid_i && !acc1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
